pipeline_ctrl: RTL and testbench
================================

// Module: pipeline_ctrl
// PURPOSE
//  Sequences the 5-stage RV32I pipeline around decode/immediate generation: detects load-use
//  and branch-in-ID data hazards, flushes IF/ID on taken branches, and freezes the pipe while
//  the data memory is busy. Sits beside the ID stage and drives PC, IF/ID, ID/EX and back-end
//  enables. Also keeps saturating stall/flush/wait counters and a sticky memory-timeout error.
// PARAMETERS
//  REG_AW      5     register-address width
//  CNT_W       32    width of each saturating event counter
//  MEM_TMO     255   max consecutive MEM_WAIT cycles before timeout (>=1)
// PORTS
//  clk_i            in   1      clock
//  rst_i            in   1      reset, asynchronous, active-low
//  start_i          in   1      run enable; low = pipeline idle
//  ifid_inst_i      in   32     instruction currently in ID
//  idex_memread_i   in   1      ID/EX holds a load
//  idex_regwrite_i  in   1      ID/EX writes rd
//  idex_rd_i        in   REG_AW ID/EX destination
//  exmem_memread_i  in   1      EX/MEM holds a load
//  exmem_rd_i       in   REG_AW EX/MEM destination
//  branch_taken_i   in   1      ID-stage comparator result
//  dmem_req_i       in   1      MEM stage access request (held until ack)
//  dmem_ack_i       in   1      data memory completion
//  pc_write_o       out  1      PC enable
//  ifid_write_o     out  1      IF/ID enable
//  ifid_flush_o     out  1      IF/ID -> NOP
//  idex_bubble_o    out  1      ID/EX control -> zero
//  pipe_hold_o      out  1      freeze ID/EX, EX/MEM, MEM/WB
//  mem_err_o        out  1      sticky timeout flag (registered)
//  stall_cnt_o      out  CNT_W  hazard-stall cycles (registered)
//  flush_cnt_o      out  CNT_W  flush cycles (registered)
//  wait_cnt_o       out  CNT_W  memory-hold cycles (registered)
// BEHAVIOUR
//  FSM: IDLE, RUN, MEM_WAIT. Reset (async) -> IDLE, counters 0, mem_err_o 0, tmo counter 0.
//  IDLE: pc_write/ifid_write/flush/hold = 0, bubble = 1. start_i=1 -> RUN at next edge.
//  RUN: start_i=0 -> IDLE; dmem_req_i & !dmem_ack_i -> MEM_WAIT; req & ack same cycle: no wait.
//  MEM_WAIT: ack -> RUN (or IDLE if start_i=0); tmo reaches MEM_TMO -> set mem_err_o, -> RUN.
//  start_i drop in MEM_WAIT ignored until exit.
//  Hold (priority 1): pipe_hold = (RUN|MEM_WAIT) & req & !ack & !timeout -> pc_write=0,
//   ifid_write=0, bubble=0, flush=0; hazard/flush suppressed, counters for them not bumped.
//  rs1 used: opcodes 0110011, 0010011, 0000011, 0100011, 1100011; rs2 used: 0110011, 0100011,
//   1100011. Register 0 never matches.
//  Hazard (priority 2): load-use = idex_memread & idex_rd==used rs;
//   branch-in-ID (opcode 1100011) also stalls on idex_regwrite & idex_rd match, or
//   exmem_memread & exmem_rd match (load->branch = 2 stall cycles).
//   Stall: pc_write=0, ifid_write=0, bubble=1, flush=0.
//  Flush (priority 3): opcode 1100011 & branch_taken_i & no stall -> ifid_flush=1,
//   pc_write=1, ifid_write=1, bubble=0.
//  Otherwise: pc_write=1, ifid_write=1, bubble=0, flush=0, hold=0.
//  Counters increment at edge for each cycle of stall/flush/hold; saturate at all-ones.
//  Control outputs combinational from state+inputs; zero-cycle latency.
// STRUCTURE
//  ctrl_pkg: opcode localparams (R, I_ALU, LOAD, STORE, BRANCH), FSM state encoding.
//  Sub-module hazard_detect: pure combinational rs-use decode + match -> stall_o.
//  Top: FSM, timeout counter, priority mux, three saturating counters.
// TESTING
//  add x5 in EX (no load), ID=add x6,x5,x1 -> no stall, pc_write=1.
//  lw x5 in EX, ID=add x6,x5,x0 -> 1 cycle bubble=1, pc_write=0; stall_cnt 0->1.
//  lw x5 in EX, ID=beq x5,x0 -> 2 stall cycles, then taken -> ifid_flush=1 once; flush_cnt=1.
//  dmem_req=1, ack after 3 cycles -> pipe_hold=1 for 3 cycles, wait_cnt=3, then RUN.
//  MEM_TMO=4, ack never -> mem_err_o=1 after 4 wait cycles, stays 1 until rst_i=0.
//  rst_i low mid-MEM_WAIT -> immediately IDLE, bubble=1, counters 0; lw x0 load-use -> no stall.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared opcodes, FSM encoding and operand-use decode for the RV32I pipeline controller.
package ctrl_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I_ALU  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_MEM_WAIT = 2'd2
    } state_t;

    function automatic logic reads_rs1(input logic [6:0] op);
        return (op == OP_R) || (op == OP_I_ALU) || (op == OP_LOAD) ||
               (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

    function automatic logic reads_rs2(input logic [6:0] op);
        return (op == OP_R) || (op == OP_STORE) || (op == OP_BRANCH);
    endfunction

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Combinational load-use and branch-in-ID hazard detection for the instruction in ID.
module hazard_detect
    import ctrl_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic [6:0]        opcode,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic              idex_memread,
    input  logic              idex_regwrite,
    input  logic [REG_AW-1:0] idex_rd,
    input  logic              exmem_memread,
    input  logic [REG_AW-1:0] exmem_rd,
    output logic              stall
);

    logic use_rs1;
    logic use_rs2;
    logic is_branch;
    logic idex_hit;
    logic exmem_hit;

    assign use_rs1   = reads_rs1(opcode) && (rs1 != '0);
    assign use_rs2   = reads_rs2(opcode) && (rs2 != '0);
    assign is_branch = (opcode == OP_BRANCH);

    assign idex_hit  = (use_rs1 && (rs1 == idex_rd))  || (use_rs2 && (rs2 == idex_rd));
    assign exmem_hit = (use_rs1 && (rs1 == exmem_rd)) || (use_rs2 && (rs2 == exmem_rd));

    // Branches resolve in ID, so they also wait on ALU results and on loads one stage further on.
    assign stall = (idex_memread && idex_hit) ||
                   (is_branch && ((idex_regwrite && idex_hit) || (exmem_memread && exmem_hit)));

endmodule

// File: rtl/pipeline_ctrl.sv
// Pipeline sequencer: run/idle/memory-wait FSM, hold > stall > flush priority, event counters.
module pipeline_ctrl
    import ctrl_pkg::*;
#(
    parameter int REG_AW  = 5,
    parameter int CNT_W   = 32,
    parameter int MEM_TMO = 255
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [31:0]       ifid_inst_i,
    input  logic              idex_memread_i,
    input  logic              idex_regwrite_i,
    input  logic [REG_AW-1:0] idex_rd_i,
    input  logic              exmem_memread_i,
    input  logic [REG_AW-1:0] exmem_rd_i,
    input  logic              branch_taken_i,
    input  logic              dmem_req_i,
    input  logic              dmem_ack_i,
    output logic              pc_write_o,
    output logic              ifid_write_o,
    output logic              ifid_flush_o,
    output logic              idex_bubble_o,
    output logic              pipe_hold_o,
    output logic              mem_err_o,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o,
    output logic [CNT_W-1:0]  wait_cnt_o,
    output state_t            state_o
);

    localparam int TMO_W = $clog2(MEM_TMO + 1);

    state_t            state_q, state_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic              set_err;
    logic              active, timeout, hold, hazard, stall, flush;
    logic [6:0]        opcode;
    logic              unused_inst_bits;

    assign opcode           = ifid_inst_i[6:0];
    assign unused_inst_bits = ^{ifid_inst_i[31:25], ifid_inst_i[14:7]};

    hazard_detect #(.REG_AW(REG_AW)) u_hazard (
        .opcode        (opcode),
        .rs1           (ifid_inst_i[15 +: REG_AW]),
        .rs2           (ifid_inst_i[20 +: REG_AW]),
        .idex_memread  (idex_memread_i),
        .idex_regwrite (idex_regwrite_i),
        .idex_rd       (idex_rd_i),
        .exmem_memread (exmem_memread_i),
        .exmem_rd      (exmem_rd_i),
        .stall         (hazard)
    );

    assign active  = (state_q != ST_IDLE);
    assign timeout = (state_q == ST_MEM_WAIT) && (tmo_q == TMO_W'(MEM_TMO));
    assign hold    = active && dmem_req_i && !dmem_ack_i && !timeout;
    assign stall   = active && !hold && hazard;
    assign flush   = active && !hold && !stall && (opcode == OP_BRANCH) && branch_taken_i;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= ST_IDLE;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        tmo_d         = '0;
        set_err       = 1'b0;
        pc_write_o    = 1'b0;
        ifid_write_o  = 1'b0;
        ifid_flush_o  = 1'b0;
        idex_bubble_o = 1'b1;
        pipe_hold_o   = 1'b0;

        if (hold) begin
            pipe_hold_o   = 1'b1;
            idex_bubble_o = 1'b0;
        end else if (active && !stall) begin
            pc_write_o    = 1'b1;
            ifid_write_o  = 1'b1;
            idex_bubble_o = 1'b0;
            ifid_flush_o  = flush;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_i) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!start_i)                       state_d = ST_IDLE;
                else if (dmem_req_i && !dmem_ack_i) state_d = ST_MEM_WAIT;
            end
            ST_MEM_WAIT: begin
                // A dropped start_i only takes effect once the access completes.
                if (dmem_ack_i) begin
                    state_d = start_i ? ST_RUN : ST_IDLE;
                end else if (timeout) begin
                    state_d = ST_RUN;
                    set_err = 1'b1;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            mem_err_o   <= 1'b0;
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
            wait_cnt_o  <= '0;
        end else begin
            if (set_err)                       mem_err_o   <= 1'b1;
            if (stall && (stall_cnt_o != '1))  stall_cnt_o <= stall_cnt_o + CNT_W'(1);
            if (flush && (flush_cnt_o != '1))  flush_cnt_o <= flush_cnt_o + CNT_W'(1);
            if (hold && (wait_cnt_o != '1))    wait_cnt_o  <= wait_cnt_o + CNT_W'(1);
        end
    end

    assign state_o = state_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed and randomized checks of pipeline_ctrl against a behavioural pipeline model.
module tb_pipeline_ctrl;
    import ctrl_pkg::*;

    localparam int REG_AW  = 5;
    localparam int CNT_W   = 4;
    localparam int MEM_TMO = 4;
    localparam int CNT_MAX = 15;
    localparam logic [31:0] NOP = 32'h0000_0013;

    // clock / reset
    logic clk = 1'b0;
    logic rst_i = 1'b0;
    always #5 clk = ~clk;

    logic              start, idex_memread, idex_regwrite, exmem_memread, taken, req, ack;
    logic [31:0]       inst;
    logic [REG_AW-1:0] idex_rd, exmem_rd;
    logic              pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold, mem_err;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt, wait_cnt;
    state_t            state;

    pipeline_ctrl #(.REG_AW(REG_AW), .CNT_W(CNT_W), .MEM_TMO(MEM_TMO)) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .start_i         (start),
        .ifid_inst_i     (inst),
        .idex_memread_i  (idex_memread),
        .idex_regwrite_i (idex_regwrite),
        .idex_rd_i       (idex_rd),
        .exmem_memread_i (exmem_memread),
        .exmem_rd_i      (exmem_rd),
        .branch_taken_i  (taken),
        .dmem_req_i      (req),
        .dmem_ack_i      (ack),
        .pc_write_o      (pc_write),
        .ifid_write_o    (ifid_write),
        .ifid_flush_o    (ifid_flush),
        .idex_bubble_o   (idex_bubble),
        .pipe_hold_o     (pipe_hold),
        .mem_err_o       (mem_err),
        .stall_cnt_o     (stall_cnt),
        .flush_cnt_o     (flush_cnt),
        .wait_cnt_o      (wait_cnt),
        .state_o         (state)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // scoreboard: expected {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold} per cycle
    logic [4:0] exp_q[$];
    logic [4:0] obs_ctrl;
    logic [4:0] e;

    // behavioural model: 0 = idle, 1 = running, 2 = waiting on memory
    int m_phase, m_waited, m_stall, m_flush, m_wait;
    bit m_err;

    function automatic logic [31:0] enc_r(int rd, int rs1, int rs2);
        return {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'(rd), 7'b0110011};
    endfunction

    function automatic logic [31:0] enc_b(int rs1, int rs2);
        return {7'd0, 5'(rs2), 5'(rs1), 3'd0, 5'd0, 7'b1100011};
    endfunction

    function automatic bit reads_reg(logic [31:0] i, logic [4:0] r);
        logic [6:0] op;
        logic [4:0] srcs[$];
        op = i[6:0];
        if (op == 7'b0110011 || op == 7'b0010011 || op == 7'b0000011 ||
            op == 7'b0100011 || op == 7'b1100011) srcs.push_back(i[19:15]);
        if (op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011) srcs.push_back(i[24:20]);
        if (r == 5'd0) return 1'b0;
        foreach (srcs[k]) if (srcs[k] == r) return 1'b1;
        return 1'b0;
    endfunction

    task automatic set_in(bit s, logic [31:0] in, bit imr, bit irw, int ird,
                          bit emr, int erd, bit tk, bit rq, bit ak);
        start = s; inst = in; idex_memread = imr; idex_regwrite = irw;
        idex_rd = REG_AW'(ird); exmem_memread = emr; exmem_rd = REG_AW'(erd);
        taken = tk; req = rq; ack = ak;
    endtask

    task automatic model_reset();
        m_phase = 0; m_waited = 0; m_stall = 0; m_flush = 0; m_wait = 0; m_err = 1'b0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        set_in(0, NOP, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_i = 1'b0;
        model_reset();
        #12;
        @(negedge clk) rst_i = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // Driver: samples the DUT's combinational response, records the model's expectation,
    // then clocks both the DUT and the model one cycle.
    task automatic drive_cycle();
        bit active, tmo, hold, is_br, haz, stall, flush;
        logic [4:0] x;
        #1;
        active = (m_phase != 0);
        tmo    = (m_phase == 2) && (m_waited == MEM_TMO);
        hold   = active && req && !ack && !tmo;
        is_br  = (inst[6:0] == 7'b1100011);
        haz    = (idex_memread && reads_reg(inst, idex_rd)) ||
                 (is_br && ((idex_regwrite && reads_reg(inst, idex_rd)) ||
                            (exmem_memread && reads_reg(inst, exmem_rd))));
        stall  = active && !hold && haz;
        flush  = active && !hold && !stall && is_br && taken;
        if (!active)    x = 5'b00010;
        else if (hold)  x = 5'b00001;
        else if (stall) x = 5'b00010;
        else            x = {2'b11, flush, 2'b00};
        exp_q.push_back(x);
        obs_ctrl = {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold};
        @(posedge clk);
        if (stall && m_stall < CNT_MAX) m_stall++;
        if (flush && m_flush < CNT_MAX) m_flush++;
        if (hold && m_wait < CNT_MAX)   m_wait++;
        case (m_phase)
            0: if (start) m_phase = 1;
            1: begin
                if (!start) m_phase = 0;
                else if (req && !ack) begin m_phase = 2; m_waited = 0; end
            end
            default: begin
                if (ack) m_phase = start ? 1 : 0;
                else if (m_waited == MEM_TMO) begin m_err = 1'b1; m_phase = 1; end
                else m_waited++;
            end
        endcase
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        obs_ctrl = {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold};
        n_checks++; if (obs_ctrl !== 5'b00010) begin n_fail++; $display("FAIL reset_ctrl: got %b expected 00010", obs_ctrl); end
        n_checks++; if (stall_cnt !== '0) begin n_fail++; $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt); end
        n_checks++; if (flush_cnt !== '0) begin n_fail++; $display("FAIL reset_flush_cnt: got %0d expected 0", flush_cnt); end
        n_checks++; if (wait_cnt !== '0) begin n_fail++; $display("FAIL reset_wait_cnt: got %0d expected 0", wait_cnt); end
        n_checks++; if (mem_err !== 1'b0) begin n_fail++; $display("FAIL reset_mem_err: got %b expected 0", mem_err); end
        n_checks++; if (state !== ST_IDLE) begin n_fail++; $display("FAIL reset_state: got %0d expected IDLE", state); end
    endtask

    task automatic test_no_stall();
        do_reset();
        set_in(1, NOP, 0, 0, 0, 0, 0, 0, 0, 0);
        drive_cycle();
        e = exp_q.pop_front();
        n_checks++; if (obs_ctrl !== e) begin n_fail++; $display("FAIL no_stall_idle: got %b expected %b", obs_ctrl, e); end
        set_in(1, enc_r(6, 5, 1), 0, 1, 5, 0, 0, 0, 0, 0);
        drive_cycle();
        e = exp_q.pop_front();
        n_checks++; if (obs_ctrl !== e || obs_ctrl !== 5'b11000) begin n_fail++; $display("FAIL no_stall_ctrl: got %b expected %b", obs_ctrl, e); end
        n_checks++; if (stall_cnt !== '0) begin n_fail++; $display("FAIL no_stall_cnt: got %0d expected 0", stall_cnt); end
    endtask

    task automatic test_load_use();
        do_reset();
        set_in(1, NOP, 0, 0, 0, 0, 0, 0, 0, 0);
        drive_cycle();
        void'(exp_q.pop_front());
        set_in(1, enc_r(6, 5, 0), 1, 1, 5, 0, 0, 0, 0, 0);
        drive_cycle();
        e = exp_q.pop_front();
        n_checks++; if (obs_ctrl !== e || obs_ctrl !== 5'b00010) begin n_fail++; $display("FAIL load_use_stall: got %b expected %b", obs_ctrl, e); end
        n_checks++; if (stall_cnt !== 4'd1) begin n_fail++; $display("FAIL load_use_cnt: got %0d expected 1", stall_cnt); end
        set_in(1, enc_r(6, 5, 0), 0, 0, 0, 1, 5, 0, 0, 0);
        drive_cycle();
        e = exp_q.pop_front();
        n_checks++; if (obs_ctrl !== e || obs_ctrl !== 5'b11000) begin n_fail++; $display("FAIL load_use_release: got %b expected %b", obs_ctrl, e); end
        n_checks++; if (stall_cnt !== 4'd1) begin n_fail++; $display("FAIL load_use_cnt_hold: got %0d expected 1", stall_cnt); end
    endtask

    task automatic test_load_branch();
        logic [4:0] want;
        do_reset();
        set_in(1, NOP, 0, 0, 0, 0, 0, 0, 0, 0);
        drive_cycle();
        void'(exp_q.pop_front());
        for (int k = 0; k < 4; k++) begin
            case (k)
                0: set_in(1, enc_b(5, 0), 1, 1, 5, 0, 0, 1, 0, 0);
                1: set_in(1, enc_b(5, 0), 0, 0, 0, 1, 5, 1, 0, 0);
                2: set_in(1, enc_b(5, 0), 0, 0, 0, 0, 0, 1, 0, 0);
                default: set_in(1, NOP, 0, 0, 0, 0, 0, 0, 0, 0);
            endcase
            want = (k < 2) ? 5'b00010 : ((k == 2) ? 5'b11100 : 5'b11000);
            drive_cycle();
            e = exp_q.pop_front();
            n_checks++; if (obs_ctrl !== e || obs_ctrl !== want) begin n_fail++; $display("FAIL load_branch step %0d: got %b expected %b", k, obs_ctrl, want); end
        end
        n_checks++; if (stall_cnt !== 4'd2) begin n_fail++; $display("FAIL load_branch_stall_cnt: got %0d expected 2", stall_cnt); end
        n_checks++; if (flush_cnt !== 4'd1) begin n_fail++; $display("FAIL load_branch_flush_cnt: got %0d expected 1", flush_cnt); end
    endtask

    task automatic test_mem_wait();
        do_reset();
        set_in(1, NOP, 0, 0, 0, 0, 0, 0, 0, 0);
        drive_cycle();
        void'(exp_q.pop_front());
        for (int k = 0; k < 5; k++) begin
            set_in(1, NOP, 0, 0, 0, 0, 0, 0, k < 4, k == 3);
            drive_cycle();
            e = exp_q.pop_front();
            n_checks++; if (obs_ctrl !== e || obs_ctrl !== ((k < 3) ? 5'b00001 : 5'b11000)) begin n_fail++; $display("FAIL mem_wait step %0d: got %b expected %b", k, obs_ctrl, e); end
        end
        n_checks++; if (wait_cnt !== 4'd3) begin n_fail++; $display("FAIL mem_wait_cnt: got %0d expected 3", wait_cnt); end
        n_checks++; if (state !== ST_RUN) begin n_fail++; $display("FAIL mem_wait_exit: got %0d expected RUN", state); end
    endtask

    task automatic test_timeout();
        do_reset();
        set_in(1, NOP, 0, 0, 0, 0, 0, 0, 0, 0);
        drive_cycle();
        void'(exp_q.pop_front());
        for (int k = 0; k < 9; k++) begin
            set_in(1, NOP, 0, 0, 0, 0, 0, 0, 1, 0);
            drive_cycle();
            e = exp_q.pop_front();
            n_checks++; if (obs_ctrl !== e) begin n_fail++; $display("FAIL timeout step %0d: got %b expected %b", k, obs_ctrl, e); end
            n_checks++; if (mem_err !== ((k >= 5) ? 1'b1 : 1'b0)) begin n_fail++; $display("FAIL timeout_err step %0d: got %b expected %b", k, mem_err, k >= 5); end
        end
        n_checks++; if (state !== ST_MEM_WAIT) begin n_fail++; $display("FAIL timeout_rewait: got %0d expected MEM_WAIT", state); end
        // asynchronous reset while waiting on memory
        rst_i = 1'b0;
        model_reset();
        #1;
        obs_ctrl = {pc_write, ifid_write, ifid_flush, idex_bubble, pipe_hold};
        n_checks++; if (obs_ctrl !== 5'b00010) begin n_fail++; $display("FAIL async_rst_ctrl: got %b expected 00010", obs_ctrl); end
        n_checks++; if (state !== ST_IDLE) begin n_fail++; $display("FAIL async_rst_state: got %0d expected IDLE", state); end
        n_checks++; if (mem_err !== 1'b0 || wait_cnt !== '0) begin n_fail++; $display("FAIL async_rst_regs: got err %b wait %0d expected 0 0", mem_err, wait_cnt); end
        @(negedge clk) rst_i = 1'b1;
        @(posedge clk);
        #1;
        set_in(1, NOP, 0, 0, 0, 0, 0, 0, 0, 0);
        drive_cycle();
        void'(exp_q.pop_front());
        set_in(1, enc_r(6, 0, 0), 1, 1, 0, 0, 0, 0, 0, 0);
        drive_cycle();
        e = exp_q.pop_front();
        n_checks++; if (obs_ctrl !== e || obs_ctrl !== 5'b11000) begin n_fail++; $display("FAIL x0_load_use: got %b expected 11000", obs_ctrl); end
    endtask

    task automatic test_random();
        logic [6:0] ops [7];
        logic [31:0] ri;
        bit pend;
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011, 7'b0110111, 7'b1101111};
        do_reset();
        pend = 1'b0;
        for (int i = 0; i < 400; i++) begin
            ri = $urandom;
            ri[6:0]   = ops[$urandom_range(0, 6)];
            ri[19:15] = 5'($urandom_range(0, 3));
            ri[24:20] = 5'($urandom_range(0, 3));
            if (!pend) pend = ($urandom_range(0, 3) == 0);
            set_in($urandom_range(0, 15) != 0, ri, $urandom_range(0, 1), $urandom_range(0, 1),
                   $urandom_range(0, 3), $urandom_range(0, 1), $urandom_range(0, 3),
                   $urandom_range(0, 1), pend, pend && ($urandom_range(0, 4) == 0));
            if (ack) pend = 1'b0;
            drive_cycle();
            e = exp_q.pop_front();
            n_checks++; if (obs_ctrl !== e) begin n_fail++; $display("FAIL rand_ctrl cyc %0d: got %b expected %b", i, obs_ctrl, e); end
            n_checks++; if (stall_cnt !== CNT_W'(m_stall)) begin n_fail++; $display("FAIL rand_stall_cnt cyc %0d: got %0d expected %0d", i, stall_cnt, m_stall); end
            n_checks++; if (flush_cnt !== CNT_W'(m_flush)) begin n_fail++; $display("FAIL rand_flush_cnt cyc %0d: got %0d expected %0d", i, flush_cnt, m_flush); end
            n_checks++; if (wait_cnt !== CNT_W'(m_wait)) begin n_fail++; $display("FAIL rand_wait_cnt cyc %0d: got %0d expected %0d", i, wait_cnt, m_wait); end
            n_checks++; if (mem_err !== m_err) begin n_fail++; $display("FAIL rand_mem_err cyc %0d: got %b expected %b", i, mem_err, m_err); end
        end
    endtask

    initial begin
        test_reset();
        test_no_stall();
        test_load_use();
        test_load_branch();
        test_mem_wait();
        test_timeout();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
